// File: rtl/ei_axi4_mon_pkg.sv
// Shared encodings, error-bit map and address-rule helpers for the AXI4 interface monitor.
package ei_axi4_mon_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  localparam int CH_AW = 0;
  localparam int CH_W  = 1;
  localparam int CH_B  = 2;
  localparam int CH_AR = 3;
  localparam int CH_R  = 4;

  localparam int ERR_VDROP_BASE = 0;
  localparam int ERR_PCHG_BASE  = 5;
  localparam int ERR_WLAST      = 10;
  localparam int ERR_RLAST      = 11;
  localparam int ERR_W_NO_AW    = 12;
  localparam int ERR_BURST      = 13;
  localparam int ERR_4K         = 14;
  localparam int ERR_OVERFLOW   = 15;

  localparam int BOUNDARY_4K = 4096;

  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
    burst_illegal = (burst == BURST_RSVD) ||
                    ((burst == BURST_WRAP) &&
                     !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

  // Byte span of an INCR burst is (len+1) << size; up to 32 KiB, so 17 bits hold the end address.
  function automatic logic crosses_4k(input logic [11:0] addr_lo, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic [16:0] end_addr;
    end_addr   = {5'd0, addr_lo} + ({8'd0, ({1'b0, len} + 9'd1)} << size);
    crosses_4k = (burst == BURST_INCR) && (end_addr > 17'(BOUNDARY_4K));
  endfunction

endpackage

// File: rtl/ei_axi4_len_fifo.sv
// In-order burst-length tracker: DEPTH x 8 FIFO; a pop frees its slot for a same-edge push.
module ei_axi4_len_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [7:0] i_din,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; r_count alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ei_axi4_interface_monitor.sv
// Passive AXI4 monitor: flags handshake/protocol violations in sticky bits and counts completions.
module ei_axi4_interface_monitor #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  input  logic                    rready,
  output logic [15:0]             err,
  output logic                    err_any,
  output logic [15:0]             wr_done_cnt,
  output logic [15:0]             rd_done_cnt
);

  import ei_axi4_mon_pkg::*;

  localparam int AX_PW = ID_WIDTH + ADDR_WIDTH + 13;
  localparam int W_PW  = DATA_WIDTH + DATA_WIDTH/8 + 1;
  localparam int B_PW  = ID_WIDTH + 2;
  localparam int R_PW  = ID_WIDTH + DATA_WIDTH + 3;

  logic [AX_PW-1:0] w_aw_pay, r_aw_pay, w_ar_pay, r_ar_pay;
  logic [W_PW-1:0]  w_w_pay,  r_w_pay;
  logic [B_PW-1:0]  w_b_pay,  r_b_pay;
  logic [R_PW-1:0]  w_r_pay,  r_r_pay;

  logic [4:0]  w_valid, w_ready, w_hs, w_pay_diff, r_stall;
  logic        r_rst_d;
  logic [7:0]  r_wbeat, r_rbeat;
  logic [15:0] r_err, w_err_new;
  logic        r_err_any;
  logic [15:0] r_wr_cnt, r_rd_cnt;

  logic [7:0] w_aw_head, w_ar_head, w_w_exp_len, w_r_exp_len;
  logic       w_aw_full, w_aw_empty, w_ar_full, w_ar_empty;
  logic       w_aw_have, w_ar_have, w_w_consume, w_r_consume;
  logic       w_aw_push, w_aw_pop, w_ar_push, w_ar_pop, w_aw_ovf, w_ar_ovf;

  assign w_aw_pay = {awid, awaddr, awlen, awsize, awburst};
  assign w_w_pay  = {wdata, wstrb, wlast};
  assign w_b_pay  = {bid, bresp};
  assign w_ar_pay = {arid, araddr, arlen, arsize, arburst};
  assign w_r_pay  = {rid, rdata, rresp, rlast};

  assign w_valid    = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign w_ready    = {rready, arready, bready, wready, awready};
  assign w_hs       = w_valid & w_ready;
  assign w_pay_diff = {w_r_pay != r_r_pay, w_ar_pay != r_ar_pay, w_b_pay != r_b_pay,
                       w_w_pay != r_w_pay, w_aw_pay != r_aw_pay};

  // An address handshake on the same edge as a data beat counts as outstanding: its len bypasses the FIFO.
  assign w_aw_have   = !w_aw_empty || w_hs[CH_AW];
  assign w_w_exp_len = w_aw_empty ? awlen : w_aw_head;
  assign w_w_consume = w_hs[CH_W] && wlast && w_aw_have;
  assign w_aw_pop    = w_hs[CH_W] && wlast && !w_aw_empty;
  assign w_aw_push   = w_hs[CH_AW] && !(w_aw_empty && w_w_consume);
  assign w_aw_ovf    = w_hs[CH_AW] && w_aw_full && !w_aw_pop;

  assign w_ar_have   = !w_ar_empty || w_hs[CH_AR];
  assign w_r_exp_len = w_ar_empty ? arlen : w_ar_head;
  assign w_r_consume = w_hs[CH_R] && rlast && w_ar_have;
  assign w_ar_pop    = w_hs[CH_R] && rlast && !w_ar_empty;
  assign w_ar_push   = w_hs[CH_AR] && !(w_ar_empty && w_r_consume);
  assign w_ar_ovf    = w_hs[CH_AR] && w_ar_full && !w_ar_pop;

  ei_axi4_len_fifo #(.DEPTH(MAX_OUTST)) u_aw_fifo (
    .i_clk(aclk), .i_rst(areset), .i_push(w_aw_push), .i_pop(w_aw_pop), .i_din(awlen),
    .o_head(w_aw_head), .o_full(w_aw_full), .o_empty(w_aw_empty)
  );

  ei_axi4_len_fifo #(.DEPTH(MAX_OUTST)) u_ar_fifo (
    .i_clk(aclk), .i_rst(areset), .i_push(w_ar_push), .i_pop(w_ar_pop), .i_din(arlen),
    .o_head(w_ar_head), .o_full(w_ar_full), .o_empty(w_ar_empty)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_err_new = '0;
    if (!r_rst_d) begin
      w_err_new[ERR_VDROP_BASE +: 5] = r_stall & ~w_valid;
      w_err_new[ERR_PCHG_BASE +: 5]  = r_stall & w_valid & w_pay_diff;
      w_err_new[ERR_WLAST]    = w_hs[CH_W] && w_aw_have && (wlast != (r_wbeat == w_w_exp_len));
      w_err_new[ERR_RLAST]    = w_hs[CH_R] && w_ar_have && (rlast != (r_rbeat == w_r_exp_len));
      w_err_new[ERR_W_NO_AW]  = w_hs[CH_W] && !w_aw_have;
      w_err_new[ERR_BURST]    = (w_hs[CH_AW] && burst_illegal(awburst, awlen)) ||
                                (w_hs[CH_AR] && burst_illegal(arburst, arlen));
      w_err_new[ERR_4K]       = (w_hs[CH_AW] && crosses_4k(awaddr[11:0], awlen, awsize, awburst)) ||
                                (w_hs[CH_AR] && crosses_4k(araddr[11:0], arlen, arsize, arburst));
      w_err_new[ERR_OVERFLOW] = w_aw_ovf || w_ar_ovf;
    end
  end

  // r_rst_d masks checks on the edge right after reset, when stall history is not yet meaningful.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rst_d   <= 1'b1;
      r_stall   <= '0;
      r_wbeat   <= '0;
      r_rbeat   <= '0;
      r_err     <= '0;
      r_err_any <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
    end else begin
      r_rst_d   <= 1'b0;
      r_stall   <= w_valid & ~w_ready;
      if (w_hs[CH_W]) r_wbeat <= wlast ? 8'd0 : r_wbeat + 8'd1;
      if (w_hs[CH_R]) r_rbeat <= rlast ? 8'd0 : r_rbeat + 8'd1;
      r_err     <= r_err | w_err_new;
      r_err_any <= |(r_err | w_err_new);
      if (w_hs[CH_B])          r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_hs[CH_R] && rlast) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  // Payload snapshots are only compared when the stall bit says they were captured under a stall.
  always_ff @(posedge aclk) begin
    r_aw_pay <= w_aw_pay;
    r_w_pay  <= w_w_pay;
    r_b_pay  <= w_b_pay;
    r_ar_pay <= w_ar_pay;
    r_r_pay  <= w_r_pay;
  end

  assign err         = r_err;
  assign err_any     = r_err_any;
  assign wr_done_cnt = r_wr_cnt;
  assign rd_done_cnt = r_rd_cnt;

endmodule

// File: tb/tb_ei_axi4_interface_monitor.sv
// Self-checking bench: address-rule vector table, directed corner sequences, and random traffic vs a queue model.
module tb_ei_axi4_interface_monitor;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MO = 4;

  logic aclk = 1'b0;
  logic areset;
  logic [IW-1:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst, bresp, rresp;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic wlast, rlast;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [15:0] err, wr_done_cnt, rd_done_cnt;
  logic        err_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  ei_axi4_interface_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTST(MO)) dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err(err), .err_any(err_any), .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queues of outstanding lengths, rules applied per edge
  logic [15:0] m_err, m_wcnt, m_rcnt;
  int          m_awq[$];
  int          m_arq[$];
  int          m_wbeat, m_rbeat;
  bit          m_prev_rst;
  bit          m_prev_stall[5];
  logic [63:0] m_prev_pay[5];

  function automatic bit bad_burst(input int burst, input int len);
    return (burst == 3) || (burst == 2 && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic bit cross4k(input int addr_lo, input int len, input int size, input int burst);
    return (burst == 1) && ((addr_lo + ((len + 1) << size)) > 4096);
  endfunction

  task automatic model_step();
    bit v[5], rd[5], hs[5], chk;
    logic [63:0] p[5];
    v  = '{awvalid, wvalid, bvalid, arvalid, rvalid};
    rd = '{awready, wready, bready, arready, rready};
    p[0] = 64'({awid, awaddr, awlen, awsize, awburst});
    p[1] = 64'({wdata, wstrb, wlast});
    p[2] = 64'({bid, bresp});
    p[3] = 64'({arid, araddr, arlen, arsize, arburst});
    p[4] = 64'({rid, rdata, rresp, rlast});
    if (areset) begin
      m_err = '0; m_wcnt = '0; m_rcnt = '0;
      m_awq.delete(); m_arq.delete();
      m_wbeat = 0; m_rbeat = 0; m_prev_rst = 1'b1;
      for (int ch = 0; ch < 5; ch++) m_prev_stall[ch] = 1'b0;
      return;
    end
    chk = !m_prev_rst;
    for (int ch = 0; ch < 5; ch++) begin
      hs[ch] = v[ch] && rd[ch];
      if (chk && m_prev_stall[ch]) begin
        if (!v[ch]) m_err[ch] = 1'b1;
        else if (p[ch] != m_prev_pay[ch]) m_err[5 + ch] = 1'b1;
      end
    end
    if (chk && hs[0] && bad_burst(int'(awburst), int'(awlen))) m_err[13] = 1'b1;
    if (chk && hs[3] && bad_burst(int'(arburst), int'(arlen))) m_err[13] = 1'b1;
    if (chk && hs[0] && cross4k(int'(awaddr[11:0]), int'(awlen), int'(awsize), int'(awburst))) m_err[14] = 1'b1;
    if (chk && hs[3] && cross4k(int'(araddr[11:0]), int'(arlen), int'(arsize), int'(arburst))) m_err[14] = 1'b1;
    // write side: accept the address first (a same-edge last beat frees a slot), then the beat
    if (hs[0]) begin
      if (m_awq.size() == MO && !(hs[1] && wlast)) begin
        if (chk) m_err[15] = 1'b1;
      end else m_awq.push_back(int'(awlen));
    end
    if (hs[1]) begin
      if (m_awq.size() == 0) begin
        if (chk) m_err[12] = 1'b1;
      end else begin
        if (chk && (wlast != ((m_wbeat % 256) == m_awq[0]))) m_err[10] = 1'b1;
        if (wlast) void'(m_awq.pop_front());
      end
      m_wbeat = wlast ? 0 : m_wbeat + 1;
    end
    if (hs[3]) begin
      if (m_arq.size() == MO && !(hs[4] && rlast)) begin
        if (chk) m_err[15] = 1'b1;
      end else m_arq.push_back(int'(arlen));
    end
    if (hs[4]) begin
      if (m_arq.size() != 0) begin
        if (chk && (rlast != ((m_rbeat % 256) == m_arq[0]))) m_err[11] = 1'b1;
        if (rlast) void'(m_arq.pop_front());
      end
      m_rbeat = rlast ? 0 : m_rbeat + 1;
      if (rlast) m_rcnt = m_rcnt + 16'd1;
    end
    if (hs[2]) m_wcnt = m_wcnt + 16'd1;
    for (int ch = 0; ch < 5; ch++) begin
      m_prev_stall[ch] = v[ch] && !rd[ch];
      m_prev_pay[ch]   = p[ch];
    end
    m_prev_rst = 1'b0;
  endtask

  // ---------------- stimulus helpers
  task automatic tick();
    model_step();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_idle();
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0; awready = 1'b1;
    {wdata, wstrb, wlast, wvalid} = '0; wready = 1'b1;
    {bid, bresp, bvalid} = '0; bready = 1'b1;
    {arid, araddr, arlen, arsize, arburst, arvalid} = '0; arready = 1'b1;
    {rid, rdata, rresp, rlast, rvalid} = '0; rready = 1'b1;
  endtask

  function automatic logic [7:0] len_pick();
    case ($urandom_range(3))
      0: return 8'd0;
      1: return 8'd1;
      2: return 8'd3;
      default: return 8'd7;
    endcase
  endfunction

  function automatic logic [1:0] burst_pick();
    if ($urandom_range(15) == 0) return 2'($urandom_range(3));
    return ($urandom_range(7) == 0) ? 2'd2 : 2'd1;
  endfunction

  // A stalled channel usually keeps valid and payload stable, so violations stay occasional.
  function automatic bit renew(input logic v, input logic r);
    return !(v && !r) || ($urandom_range(99) >= 95);
  endfunction

  task automatic rand_bus();
    if (renew(awvalid, awready)) begin
      awvalid = 1'($urandom_range(1)); awid = IW'($urandom); awaddr = $urandom;
      if ($urandom_range(3) == 0) awaddr[11:0] = 12'hFF0 + 12'($urandom_range(15));
      awlen = len_pick(); awsize = 3'($urandom_range(2)); awburst = burst_pick();
    end
    if (renew(wvalid, wready)) begin
      wvalid = 1'($urandom_range(1)); wdata = $urandom; wstrb = 4'($urandom);
      wlast = 1'($urandom_range(4) < 2);
    end
    if (renew(bvalid, bready)) begin
      bvalid = 1'($urandom_range(1)); bid = IW'($urandom); bresp = 2'($urandom);
    end
    if (renew(arvalid, arready)) begin
      arvalid = 1'($urandom_range(1)); arid = IW'($urandom); araddr = $urandom;
      if ($urandom_range(3) == 0) araddr[11:0] = 12'hFF0 + 12'($urandom_range(15));
      arlen = len_pick(); arsize = 3'($urandom_range(2)); arburst = burst_pick();
    end
    if (renew(rvalid, rready)) begin
      rvalid = 1'($urandom_range(1)); rid = IW'($urandom); rdata = $urandom; rresp = 2'($urandom);
      rlast = 1'($urandom_range(4) < 2);
    end
    awready = 1'($urandom_range(3) != 0);
    wready  = 1'($urandom_range(3) != 0);
    bready  = 1'($urandom_range(3) != 0);
    arready = 1'($urandom_range(3) != 0);
    rready  = 1'($urandom_range(3) != 0);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    rand_bus(); tick();
    rand_bus(); tick();
    areset = 1'b0;
    set_idle(); tick();
  endtask

  task automatic aw_beat(input logic [31:0] addr, input logic [7:0] len);
    awvalid = 1'b1; awaddr = addr; awlen = len; awsize = 3'd2; awburst = 2'd1;
  endtask

  task automatic ar_beat(input logic [31:0] addr, input logic [7:0] len);
    arvalid = 1'b1; araddr = addr; arlen = len; arsize = 3'd2; arburst = 2'd1;
  endtask

  typedef struct {
    bit          use_ar;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs[16];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, 32'h0000_0100, 8'd3,   3'd2, 2'd1, 16'h0000};
    vecs[1]  = '{1, 32'h0000_0FF8, 8'd3,   3'd2, 2'd1, 16'h4000};
    vecs[2]  = '{0, 32'h0000_0FF0, 8'd3,   3'd2, 2'd1, 16'h0000};
    vecs[3]  = '{1, 32'h0000_0FF1, 8'd3,   3'd2, 2'd1, 16'h4000};
    vecs[4]  = '{0, 32'h0000_0000, 8'd255, 3'd4, 2'd1, 16'h0000};
    vecs[5]  = '{1, 32'h0000_0010, 8'd255, 3'd4, 2'd1, 16'h4000};
    vecs[6]  = '{0, 32'h0000_0000, 8'd0,   3'd2, 2'd3, 16'h2000};
    vecs[7]  = '{1, 32'h0000_0FF8, 8'd3,   3'd2, 2'd2, 16'h0000};
    vecs[8]  = '{0, 32'h0000_0000, 8'd2,   3'd2, 2'd2, 16'h2000};
    vecs[9]  = '{1, 32'h0000_0000, 8'd15,  3'd2, 2'd2, 16'h0000};
    vecs[10] = '{0, 32'h0000_0000, 8'd16,  3'd2, 2'd2, 16'h2000};
    vecs[11] = '{1, 32'h0000_0FFF, 8'd7,   3'd0, 2'd0, 16'h0000};
    vecs[12] = '{0, 32'h0000_1FF8, 8'd1,   3'd2, 2'd1, 16'h0000};
    vecs[13] = '{1, 32'hABCD_EFFC, 8'd1,   3'd2, 2'd1, 16'h4000};
    vecs[14] = '{0, 32'h0000_0C00, 8'd7,   3'd7, 2'd1, 16'h0000};
    vecs[15] = '{1, 32'h0000_0C01, 8'd7,   3'd7, 2'd1, 16'h4000};

    areset = 1'b1;
    set_idle();

    // reset with random bus activity
    rand_bus(); tick(); rand_bus(); tick();
    check("reset_err", err, 0);
    check("reset_err_any", err_any, 0);
    check("reset_wr_cnt", wr_done_cnt, 0);
    check("reset_rd_cnt", rd_done_cnt, 0);
    areset = 1'b0; set_idle(); tick();

    // clean 4-beat write
    aw_beat(32'h100, 8'd3); tick(); awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wvalid = 1'b1; wdata = 32'(i); wstrb = 4'hF; wlast = (i == 3); tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    bvalid = 1'b1; tick(); bvalid = 1'b0; tick();
    check("clean_write_err", err, 0);
    check("clean_write_err_any", err_any, 0);
    check("clean_write_cnt", wr_done_cnt, 1);

    // AR valid dropped while stalled
    do_reset();
    ar_beat(32'h0, 8'd0); arready = 1'b0; tick();
    arvalid = 1'b0; arready = 1'b1; tick();
    check("ar_drop_err", err, 16'h0008);
    check("ar_drop_err_any", err_any, 1);
    repeat (10) tick();
    check("ar_drop_sticky", err, 16'h0008);

    // W payload changed while stalled
    do_reset();
    wvalid = 1'b1; wready = 1'b0; wdata = 32'hA5A5_A5A5; tick();
    wdata = 32'h5A5A_5A5A; tick();
    check("w_payload_change", err, 16'h0040);

    // early WLAST, then a clean burst leaves err unchanged
    do_reset();
    aw_beat(32'h200, 8'd3); tick(); awvalid = 1'b0;
    wvalid = 1'b1; wlast = 1'b0; tick();
    wlast = 1'b1; tick();
    wvalid = 1'b0; wlast = 1'b0;
    check("wlast_early", err, 16'h0400);
    aw_beat(32'h300, 8'd1); tick(); awvalid = 1'b0;
    wvalid = 1'b1; wlast = 1'b0; tick(); wlast = 1'b1; tick();
    wvalid = 1'b0; wlast = 1'b0;
    bvalid = 1'b1; tick(); tick(); bvalid = 1'b0;
    check("wlast_next_clean", err, 16'h0400);
    check("wlast_wr_cnt", wr_done_cnt, 2);

    // 4KB crossing on AR, then AW FIFO overflow on the fifth address
    do_reset();
    ar_beat(32'hFF8, 8'd3); tick(); arvalid = 1'b0;
    check("ar_4k_cross", err, 16'h4000);
    for (int i = 0; i < 4; i++) begin aw_beat(32'(i * 16), 8'd0); tick(); end
    awvalid = 1'b0; tick();
    check("aw_fifo_four", err, 16'h4000);
    aw_beat(32'h400, 8'd0); tick(); awvalid = 1'b0;
    check("aw_fifo_overflow", err, 16'hC000);

    // same-edge bypass, push+pop at full, drain, then a W with nothing outstanding
    do_reset();
    aw_beat(32'h0, 8'd0); wvalid = 1'b1; wlast = 1'b1; tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("bypass_single", err, 0);
    for (int i = 0; i < 4; i++) begin aw_beat(32'(i * 64), 8'd0); tick(); end
    aw_beat(32'h800, 8'd0); wvalid = 1'b1; wlast = 1'b1; tick(); awvalid = 1'b0;
    repeat (4) tick();
    wvalid = 1'b0;
    check("full_push_pop_drain", err, 0);
    wvalid = 1'b1; tick(); wvalid = 1'b0;
    check("w_without_aw", err, 16'h1000);

    // no check on the edge after reset, checks resume on the next one
    areset = 1'b1; set_idle(); wvalid = 1'b1; wlast = 1'b1; tick();
    areset = 1'b0; tick();
    check("post_reset_masked", err, 0);
    tick(); wvalid = 1'b0;
    check("post_reset_resumed", err, 16'h1000);

    // reads: clean two-beat burst, then a late RLAST
    do_reset();
    ar_beat(32'h40, 8'd1); tick(); arvalid = 1'b0;
    rvalid = 1'b1; rlast = 1'b0; tick(); rlast = 1'b1; tick();
    check("read_clean", err, 0);
    check("read_cnt1", rd_done_cnt, 1);
    ar_beat(32'h80, 8'd0); rvalid = 1'b0; tick(); arvalid = 1'b0;
    rvalid = 1'b1; rlast = 1'b0; tick();
    check("rlast_late", err, 16'h0800);
    rlast = 1'b1; tick(); rvalid = 1'b0; rlast = 1'b0;
    check("read_cnt2", rd_done_cnt, 2);

    // address-rule vector table
    for (int i = 0; i < 16; i++) begin
      do_reset();
      if (vecs[i].use_ar) begin
        arvalid = 1'b1; araddr = vecs[i].addr; arlen = vecs[i].len;
        arsize = vecs[i].size; arburst = vecs[i].burst;
      end else begin
        awvalid = 1'b1; awaddr = vecs[i].addr; awlen = vecs[i].len;
        awsize = vecs[i].size; awburst = vecs[i].burst;
      end
      tick();
      set_idle(); tick();
      check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
    end

    // random traffic against the model, reset between segments (often mid-burst)
    for (int seg = 0; seg < 8; seg++) begin
      areset = 1'b1;
      rand_bus(); tick(); rand_bus(); tick();
      areset = 1'b0;
      for (int c = 0; c < 60; c++) begin
        rand_bus(); tick();
        check("rand_err", err, m_err);
        check("rand_err_any", err_any, (m_err != 0));
        check("rand_wr_cnt", wr_done_cnt, m_wcnt);
        check("rand_rd_cnt", rd_done_cnt, m_rcnt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ei_axi4_interface_monitor.md
Name: ei_axi4_interface_monitor

Overview:
- Passive AXI4 bus-interface monitor that sits on the master-to-slave AXI4 wire bundle between the master and slave VIP components.
- Samples all five channels (AW, W, B, AR, R) on every rising clock edge.
- Flags handshake and protocol violations in sticky error bits.
- Counts completed write and read transactions.
- Drives nothing onto the bus.

Parameters:
- ADDR_WIDTH, 32, address width of AW/AR.
- DATA_WIDTH, 32, data width of W/R; wstrb is DATA_WIDTH/8.
- ID_WIDTH, 4, transaction ID width.
- MAX_OUTST, 4, depth of the in-order AWLEN and ARLEN tracking FIFOs (power of 2).

Ports:
- aclk  input  1  single clock; all sampling on its rising edge.
- areset  input  1  synchronous, active-high reset.
- awid/awaddr/awlen/awsize/awburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload.
- awvalid, awready  input  1 each  AW handshake.
- wdata/wstrb/wlast  input  DATA_WIDTH/DATA_WIDTH/8/1  W payload.
- wvalid, wready  input  1 each  W handshake.
- bid/bresp  input  ID_WIDTH/2  B payload.
- bvalid, bready  input  1 each  B handshake.
- arid/araddr/arlen/arsize/arburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  AR payload.
- arvalid, arready  input  1 each  AR handshake.
- rid/rdata/rresp/rlast  input  ID_WIDTH/DATA_WIDTH/2/1  R payload.
- rvalid, rready  input  1 each  R handshake.
- err  output  16  sticky violation flags; bit map under Behaviour.
- err_any  output  1  OR of err, registered together with err.
- wr_done_cnt  output  16  count of B handshakes; wraps at 0xFFFF to 0.
- rd_done_cnt  output  16  count of R handshakes with rlast=1; wraps the same way.

Behaviour:
- Handshake: a beat transfers on a rising edge where valid=1 and ready=1.
- Stalled: valid=1 and ready=0 at edge N. Each channel registers its stalled state and its payload.
- Reset (areset=1 at an edge):
  - err, err_any and both counters go to 0.
  - Both FIFOs empty; W and R beat counters 0; stall history cleared.
  - No check fires on the edge that samples areset=1 or on the following edge.
  - Reset mid-burst discards all tracking state.
- Error bit assignment (each bit sticky once set, until reset):
  - err[0..4] valid dropped: the channel (AW, W, B, AR, R in that order) was stalled at edge N-1 and valid=0 at edge N.
  - err[5..9] payload changed: same channel order; stalled at N-1, valid=1 at N, any payload bit differs.
  - err[10] WLAST mismatch: on a W handshake, wlast != (wbeat == head AWLEN).
  - err[11] RLAST mismatch: on an R handshake, rlast != (rbeat == head ARLEN). Reads are tracked in order, ignoring ID.
  - err[12] W beat accepted with no outstanding AW. A same-edge AW handshake counts, and its awlen bypasses the FIFO.
  - err[13] illegal burst on AW or AR handshake: burst=2'b11, or burst=WRAP with len not in {1,3,7,15}.
  - err[14] 4KB crossing on an INCR handshake: (addr[11:0] + ((len+1) << size)) > 4096.
  - err[15] AW or AR handshake while its FIFO is full; the entry is dropped.
- Beat counters:
  - wbeat/rbeat increment on each handshake of their channel.
  - On an rlast/wlast handshake: counter returns to 0 and the FIFO pops, regardless of mismatch.
  - A mismatched beat with no last flag does not pop; beats continue.
- Same-edge FIFO push and pop: legal at any fill level, including full (the pop frees the slot).
- Outputs are registered: an error condition at edge N is visible after edge N.
- Counters increment on the handshake edge.

Decomposition:
- Package ei_axi4_mon_pkg holds:
  - burst encodings FIXED=0, INCR=1, WRAP=2;
  - error-bit index constants;
  - a 4KB boundary constant.
- One sub-module, ei_axi4_len_fifo: MAX_OUTST x 8 FIFO with push, pop, head, full and empty. It is instantiated twice, for AW and AR.

Test Plan:
- Reset: hold areset=1 for 2 cycles with random bus values -> err=0, err_any=0, wr_done_cnt=0, rd_done_cnt=0.
- Clean write: AW awlen=3 INCR addr 0x100 size 2; 4 W beats, wlast on the 4th; B handshake -> err=0, wr_done_cnt=1.
- Valid drop: arvalid=1 with arready=0 for 1 cycle, then arvalid=0 -> err[3]=1, err_any=1, still set 10 cycles later.
- Payload change: wvalid=1, wready=0, wdata 0xA5A5A5A5 changed to 0x5A5A5A5A while stalled -> err[6]=1 only.
- WLAST early: AW awlen=3; W beats with wlast on beat 2 -> err[10]=1; the next AW/W burst with no error leaves err unchanged.
- Boundary checks: AR araddr=0xFF8, arlen=3, size=2, INCR -> err[14]=1. Then 5 AW handshakes with no W -> err[15]=1 on the 5th.
